// File: rtl/ram_master.sv
// Host-side initiator for a single-port synchronous RAM: valid/ready request in, registered RAM port
// out, read data returned over valid/ready. Define RAM_MASTER_CLEAR_EN to zero the RAM after reset.
module ram_master #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  // StReset only exists while rst_n is held; it keeps req_ready low and busy high until the
  // first edge after release.
  typedef enum logic [2:0] {
    StReset,
`ifdef RAM_MASTER_CLEAR_EN
    StClear,
`endif
    StIdle,
    StRdIssue,
    StRdWait,
    StRsp
  } state_e;

  state_e state_q, state_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              accept;

`ifdef RAM_MASTER_CLEAR_EN
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign accept    = req_valid && req_ready;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef RAM_MASTER_CLEAR_EN
      StReset:   state_d = StClear;
      StClear:   if (clr_cnt_q == LastAddr) state_d = StIdle;
`else
      StReset:   state_d = StIdle;
`endif
      StIdle:    if (accept && !req_we) state_d = StRdIssue;
      StRdIssue: state_d = StRdWait;
      StRdWait:  state_d = StRsp;
      StRsp:     if (rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic: next values for the registered RAM port and response channel
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef RAM_MASTER_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    unique case (state_q)
`ifdef RAM_MASTER_CLEAR_EN
      StClear: begin
        ram_en_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = clr_cnt_q;
        ram_din_d  = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
      end
`endif
      StIdle: begin
        if (accept) begin
          ram_en_d   = 1'b1;
          ram_we_d   = req_we;
          ram_addr_d = req_addr;
          if (req_we) ram_din_d = req_wdata;
        end
      end
      StRdWait: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ram_dout;
      end
      StRsp: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef RAM_MASTER_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a behavioural registered-output RAM and a response
// scoreboard; covers the clear sequence too when RAM_MASTER_CLEAR_EN is defined.
module tb_ram_master;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] mem [8] = '{default: '0};

  ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Response monitor: every completed handshake must match the oldest expected read
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else                  check_eq("rsp_data", 32'(rsp_data), 32'(sb_q.pop_front()));
    end
  end

  // Present a request and return #1 after the accepting edge
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic got = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("req_accept_timeout", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    if (we) ref_mem[addr] = data;
  endtask

  // Read with rsp_ready high: checks the two-cycle latency, scoreboard checks the data
  task automatic do_read(input logic [AW-1:0] addr);
    sb_q.push_back(ref_mem[addr]);
    do_req(1'b0, addr, '0);
    check_eq("rd_lat_t0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_lat_t1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_lat_t2", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check_eq("rd_done", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // Reset values
    #2;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_din", 32'(ram_din), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef RAM_MASTER_CLEAR_EN
    begin
      int n_clr = 0;
      // Preload garbage so the clear is observable through a read
      for (int i = 0; i < 8; i++) mem[i] = 8'hA5;
      check_eq("clr_busy", 32'(busy), 32'd1);
      check_eq("clr_req_ready", 32'(req_ready), 32'd0);
      for (int c = 0; c < 20; c++) begin
        if (ram_en && ram_we) begin
          check_eq("clr_addr", 32'(ram_addr), 32'(n_clr));
          check_eq("clr_din", 32'(ram_din), 32'd0);
          n_clr++;
        end
        if (!busy) break;
        @(posedge clk); #1;
      end
      check_eq("clr_count", 32'(n_clr), 32'd8);
      check_eq("clr_done_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      do_read(3'd3);
    end
`else
    check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
`endif

    // Back-to-back writes
    do_req(1'b1, 3'd3, 8'd77);
    check_eq("wr0_en", 32'(ram_en), 32'd1);
    check_eq("wr0_we", 32'(ram_we), 32'd1);
    check_eq("wr0_addr", 32'(ram_addr), 32'd3);
    check_eq("wr0_din", 32'(ram_din), 32'd77);
    check_eq("wr0_ready", 32'(req_ready), 32'd1);
    do_req(1'b1, 3'd5, 8'd144);
    check_eq("wr1_en", 32'(ram_en), 32'd1);
    check_eq("wr1_we", 32'(ram_we), 32'd1);
    check_eq("wr1_addr", 32'(ram_addr), 32'd5);
    check_eq("wr1_din", 32'(ram_din), 32'd144);
    check_eq("wr1_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("wr_idle_en", 32'(ram_en), 32'd0);
    check_eq("wr_idle_addr", 32'(ram_addr), 32'd5);

    // Reads return the written data
    do_read(3'd5);
    do_read(3'd3);

    // Response held while rsp_ready is low
    rsp_ready = 1'b0;
    sb_q.push_back(ref_mem[3]);
    do_req(1'b0, 3'd3, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_data", 32'(rsp_data), 32'd77);
      check_eq("hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_done_valid", 32'(rsp_valid), 32'd0);
    check_eq("hold_done_ready", 32'(req_ready), 32'd1);
    check_eq("hold_data_kept", 32'(rsp_data), 32'd77);

    // Write immediately followed by read of the same address
    do_req(1'b1, 3'd7, 8'd200);
    do_read(3'd7);

    // Reset while in RD_WAIT discards the read
    do_req(1'b0, 3'd2, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("mid_rst_idle_timeout");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_master.md
# ram_master

Initiator for the team's 8-entry single-port synchronous RAM. Accepts single-word read/write requests from a host over a valid/ready handshake and drives the RAM port (enable, write-enable, address, write data). Captures the RAM's registered read data and returns it to the host over a valid/ready response channel. Sits between any host engine (test sequencer, DMA, CPU shim) and one RAM instance.

## Interface
Parameters:
- ADDR_W, 3, RAM address width
- DATA_W, 8, RAM data width
- DEPTH, 1<<ADDR_W, number of RAM words, used by the clear sequence

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  master can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  host accepts read data
- rsp_data  output  DATA_W  read data
- ram_en  output  1  to RAM en
- ram_we  output  1  to RAM we
- ram_addr  output  ADDR_W  to RAM addr
- ram_din  output  DATA_W  to RAM data_in
- ram_dout  input  DATA_W  from RAM data_out (registered in the RAM)
- busy  output  1  high whenever state is not IDLE

## Operation
- States: CLEAR (only with macro), IDLE, RD_ISSUE, RD_WAIT, RSP.
- All RAM-side outputs registered; no combinational path from req_* to ram_*.
- req_ready = 1 only in IDLE; accept = req_valid && req_ready at a rising edge.
- Write accept in IDLE: register ram_en=1, ram_we=1, ram_addr=req_addr, ram_din=req_wdata; stay IDLE. Back-to-back writes every cycle allowed; no response generated.
- Read accept in IDLE: register ram_en=1, ram_we=0, ram_addr=req_addr; go RD_ISSUE.
- RD_ISSUE: RAM samples the read at this edge; deassert ram_en; go RD_WAIT.
- RD_WAIT: capture ram_dout into rsp_data; set rsp_valid=1; go RSP.
- RSP: hold rsp_valid and rsp_data stable until rsp_ready; on rsp_valid && rsp_ready clear rsp_valid, go IDLE.
- IDLE with no accept: ram_en=0, ram_we=0; ram_addr/ram_din hold last value.
- req_we, req_addr, req_wdata ignored when no accept.
- rsp_data holds last read value after handshake until next read capture.

## Timing
- Reset (async assert, any state): req_ready=0, rsp_valid=0, rsp_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, busy=1. Next state CLEAR when macro defined, else IDLE. Leaving reset into IDLE: req_ready=1, busy=0 at first edge after rst_n deasserts.
- Write latency: accept at edge T, RAM writes at edge T+1.
- Read latency: accept at edge T, rsp_valid=1 after edge T+2; earliest next accept at the edge after the response handshake.
- Write accepted at T followed by read of same address accepted at T+1 returns the new data, since the RAM write completes before the read is sampled.
- rst_n asserted mid-read or mid-response: read discarded, no rsp_valid.

## Configuration
- RAM_MASTER_CLEAR_EN defined: after reset, state CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle (ram_en=1, ram_we=1, ram_din=0, ram_addr incrementing). The clear takes DEPTH cycles, then the block moves to IDLE. req_ready=0 and busy=1 throughout. Reset during CLEAR restarts at address 0.
- Not defined: CLEAR state and address counter absent; reset goes directly to IDLE; RAM contents are whatever the RAM holds.

## Test plan
- Write 77 to addr 3, write 144 to addr 5 on consecutive cycles -> ram_en=ram_we=1 for two cycles with addr 3 then 5; req_ready stays 1.
- After those writes, read addr 5 then addr 3 with rsp_ready=1 -> rsp_data=144 then 77, each rsp_valid 2 cycles after accept.
- Read addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=77 held; req_ready=0; completes on the cycle rsp_ready rises.
- Write 200 to addr 7 immediately followed by read addr 7 -> rsp_data=200.
- Assert rst_n=0 in RD_WAIT -> all outputs reach reset values immediately; no response after release.
- With RAM_MASTER_CLEAR_EN: release reset -> 8 zero-writes to addrs 0..7, then busy=0; read addr 3 -> 0.
